// File: rtl/rx_interface_if.sv
// Bus bundle for rx_interface: serial line in, word FIFO read side out.
// master = producer/consumer side (drives RX and RD), slave = rx_interface.
interface rx_interface_if;
    logic        RX;
    logic        RD;
    logic [15:0] DATA_OUT;
    logic        EMPTY;
    logic        FULL;
    logic        FRAME_ERR;
    logic        OVERRUN;

    modport master (
        output RX, RD,
        input  DATA_OUT, EMPTY, FULL, FRAME_ERR, OVERRUN
    );

    modport slave (
        input  RX, RD,
        output DATA_OUT, EMPTY, FULL, FRAME_ERR, OVERRUN
    );
endinterface

// File: rtl/rx_interface.sv
// rx_interface: 8N1 UART receiver (16x oversampling) that pairs bytes
// low-then-high into 16-bit words and queues them in a show-ahead FIFO.
// Optional feature macro: RX_TIMEOUT_EN -- drops a held low byte when its
// high byte does not arrive within TO_TICKS baud ticks.
module rx_interface #(
    parameter int DVSR     = 163,
    parameter int DVSR_W   = 8,
    parameter int SB_TICK  = 16,
    parameter int FIFO_AW  = 2,
    parameter int TO_TICKS = 320
) (
    input  logic         CLK,
    input  logic         RESET,
    rx_interface_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int SW    = $clog2((SB_TICK > 16) ? SB_TICK : 16);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic              rx_meta, rx_sync;
    logic [DVSR_W-1:0] baud_cnt;
    logic              tick;

    state_t            state;
    logic [SW-1:0]     s_cnt;
    logic [2:0]        n_cnt;
    logic [7:0]        shreg;
    logic              byte_done;
    logic              frame_err;
    logic              brk_wait;

    logic              byte_sel;
    logic [7:0]        lo_byte;
    logic [15:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] w_ptr, r_ptr;
    logic [FIFO_AW:0]  count, count_nxt;
    logic              empty_r, full_r, overrun;
    logic              push, rd_en, wr_ok;

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_TICKS + 1);
    logic [TO_W-1:0]   to_cnt;
`endif

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.RX;
            rx_sync <= rx_meta;
        end
    end

    // Free-running baud-tick divider.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            baud_cnt <= '0;
        else if (baud_cnt == DVSR_W'(DVSR - 1))
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    assign tick = (baud_cnt == DVSR_W'(DVSR - 1));

    // Receive FSM: start-bit check at mid-bit, 8 data bits LSB first, stop bit.
    // After a bad stop bit with the line still low, wait for the line to go
    // high before accepting a new start so a break is not decoded as frames.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            brk_wait  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (brk_wait) begin
                            if (rx_sync) brk_wait <= 1'b0;
                        end else if (!rx_sync) begin
                            state <= START;
                            s_cnt <= '0;
                        end
                    end
                    START: begin
                        if (s_cnt == SW'(7)) begin
                            if (!rx_sync) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (s_cnt == SW'(15)) begin
                            s_cnt <= '0;
                            shreg <= {rx_sync, shreg[7:1]};
                            if (n_cnt == 3'd7)
                                state <= STOP;
                            else
                                n_cnt <= n_cnt + 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (s_cnt == SW'(SB_TICK - 1)) begin
                            state <= IDLE;
                            if (rx_sync) begin
                                byte_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                brk_wait  <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign push  = byte_done & byte_sel;
    assign rd_en = bus.RD & ~empty_r;
    assign wr_ok = push & (~full_r | rd_en);

    // Next occupancy, so FULL/EMPTY can be registered exactly.
    always_comb begin
        count_nxt = count + (FIFO_AW + 1)'(wr_ok) - (FIFO_AW + 1)'(rd_en);
    end

    // Byte pairing and word FIFO; byte_sel lives here so the optional
    // timeout shares its single driver.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            byte_sel <= 1'b0;
            lo_byte  <= '0;
            w_ptr    <= '0;
            r_ptr    <= '0;
            count    <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            overrun  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef RX_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            overrun <= 1'b0;
            if (byte_done) begin
                byte_sel <= ~byte_sel;
                if (!byte_sel) lo_byte <= shreg;
`ifdef RX_TIMEOUT_EN
                to_cnt <= '0;
            end else if (tick && byte_sel && state == IDLE) begin
                if (to_cnt == TO_W'(TO_TICKS - 1)) begin
                    byte_sel <= 1'b0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else if (state != IDLE || !byte_sel) begin
                to_cnt <= '0;
`endif
            end
            if (rd_en) r_ptr <= r_ptr + 1'b1;
            if (wr_ok) begin
                mem[w_ptr] <= {shreg, lo_byte};
                w_ptr      <= w_ptr + 1'b1;
            end
            if (push && full_r && !rd_en) overrun <= 1'b1;
            count   <= count_nxt;
            empty_r <= (count_nxt == '0);
            full_r  <= (count_nxt == (FIFO_AW + 1)'(DEPTH));
        end
    end

    assign bus.DATA_OUT  = empty_r ? '0 : mem[r_ptr];
    assign bus.EMPTY     = empty_r;
    assign bus.FULL      = full_r;
    assign bus.FRAME_ERR = frame_err;
    assign bus.OVERRUN   = overrun;
endmodule
